// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam int DEF_BAUD = 9600;
  localparam int DEF_CLKF = 100000000;
  localparam int DEF_DLEN = 8;
  localparam int DEF_OS   = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clkf, input int baud, input int os);
    longint den;
    den = longint'(baud) * longint'(os);
    return int'((longint'(clkf) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick divider with sync restart
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // A restart realigns the tick phase, so the pending tick is dropped.
  assign tick = !restart && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - oversampling UART receiver with 3-sample majority vote
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int BAUD = DEF_BAUD,
  parameter int CLKF = DEF_CLKF,
  parameter int DLEN = DEF_DLEN,
  parameter int OS   = DEF_OS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rxs,
  output logic            o_rvalid,
  output logic [DLEN-1:0] o_rdata,
  output logic            o_ferr,
  output logic            o_nerr,
  output logic            o_busy
);

  localparam int DIV = baud_div(CLKF, BAUD, OS);
  localparam int TW  = $clog2(OS);
  localparam int BW  = $clog2(DLEN);

  localparam logic [TW-1:0] T_S0  = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OS / 2);
  localparam logic [TW-1:0] T_S2  = TW'(OS / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DLEN - 1);

  rx_state_e       state, state_nxt;
  logic            prev_rxs;
  logic            start_edge;
  logic            tick;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            s0, s1;
  logic            vote, split;
  logic            nerr_acc;
  logic [DLEN-1:0] shreg;
  logic            at_s2, at_end;

  assign start_edge = (state == RX_IDLE) && prev_rxs && !i_rxs;
  assign at_s2      = tick && (tick_cnt == T_S2);
  assign at_end     = tick && (tick_cnt == T_END);

  // Third sample is the live line value at tick OS/2+1.
  assign vote  = (s0 & s1) | (s0 & i_rxs) | (s1 & i_rxs);
  assign split = !((s0 == s1) && (s1 == i_rxs));

  assign o_busy = (state != RX_IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (start_edge) state_nxt = RX_START;
      RX_START: begin
        if (at_s2 && vote) begin
          state_nxt = RX_IDLE;
        end else if (at_end) begin
          state_nxt = RX_DATA;
        end
      end
      RX_DATA:  if (at_end && (bit_cnt == B_LAST)) state_nxt = RX_STOP;
      RX_STOP:  if (at_s2) state_nxt = vote ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (tick && i_rxs && (tick_cnt == T_END)) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_rxs <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      nerr_acc <= 1'b0;
      shreg    <= '0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_ferr   <= 1'b0;
      o_nerr   <= 1'b0;
    end else begin
      prev_rxs <= i_rxs;
      o_rvalid <= 1'b0;
      o_ferr   <= 1'b0;
      o_nerr   <= 1'b0;

      // In BREAK the tick counter counts consecutive high ticks instead of bit phase.
      if ((state == RX_IDLE) || (state_nxt != state)) begin
        tick_cnt <= '0;
      end else if (tick) begin
        if (state == RX_BREAK) begin
          tick_cnt <= i_rxs ? tick_cnt + 1'b1 : '0;
        end else begin
          tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
        end
      end

      if (tick && (tick_cnt == T_S0)) s0 <= i_rxs;
      if (tick && (tick_cnt == T_S1)) s1 <= i_rxs;

      if (start_edge) begin
        nerr_acc <= 1'b0;
        bit_cnt  <= '0;
      end else if (at_s2 && split && (state inside {RX_START, RX_DATA, RX_STOP})) begin
        nerr_acc <= 1'b1;
      end

      if (state == RX_DATA) begin
        if (at_s2) shreg <= {vote, shreg[DLEN-1:1]};
        if (at_end && (bit_cnt != B_LAST)) bit_cnt <= bit_cnt + 1'b1;
      end

      if ((state == RX_STOP) && at_s2) begin
        o_nerr <= nerr_acc | split;
        if (vote) begin
          o_rvalid <= 1'b1;
          o_rdata  <= shreg;
        end else begin
          o_ferr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - self-checking bench for uart_rx_os16
module tb_uart_rx_os16;

  localparam int CLKF = 1000000;
  localparam int BAUD = 12000;
  localparam int OS   = 16;
  localparam int DLEN = 8;
  localparam int DIV  = 5;
  localparam int BITC = OS * DIV;
  localparam int STOP_LAT = (9 * OS + OS / 2 + 2) * DIV + 1;
  localparam int BUDGET = 20 * BITC;

  typedef struct {
    logic [7:0] data;
    logic       nerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxs = 1'b1;
  logic       rvalid;
  logic [7:0] rdata;
  logic       ferr;
  logic       nerr;
  logic       busy;

  int   cyc = 0;
  int   t0 = 0;
  int   rv_cnt = 0;
  int   fe_cnt = 0;
  logic fe_nerr = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  uart_rx_os16 #(
    .BAUD(BAUD),
    .CLKF(CLKF),
    .DLEN(DLEN),
    .OS  (OS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_rxs    (rxs),
    .o_rvalid (rvalid),
    .o_rdata  (rdata),
    .o_ferr   (ferr),
    .o_nerr   (nerr),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rvalid) rv_cnt <= rv_cnt + 1;
    if (ferr) begin
      fe_cnt  <= fe_cnt + 1;
      fe_nerr <= nerr;
    end
  end

  // Drives one frame cycle by cycle; cycles in [lo,hi) are inverted; ncyc>0 truncates.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bitc,
                            input int lo, input int hi, input int ncyc);
    logic [9:0] frame;
    int         total;
    logic       v;
    frame = {stop, d, 1'b0};
    total = (ncyc > 0) ? ncyc : 10 * bitc;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      v = frame[c / bitc];
      if (c >= lo && c < hi) v = ~v;
      rxs = v;
      if (c == 0) t0 = cyc;
    end
  endtask

  task automatic idle_bits(input int n);
    rxs = 1'b1;
    repeat (n * BITC) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxs = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    n_checks++; if (nerr !== 1'b0) begin n_fail++; $display("FAIL reset_nerr: got %b expected 0", nerr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_clean();
    int fe0;
    fe0 = fe_cnt;
    exp_q.push_back('{data: 8'hA5, nerr: 1'b0});
    fork
      send_frame(8'hA5, 1'b1, BITC, -1, -1, 0);
      begin
        repeat (4 * BITC) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy: got %b expected 1", busy); end
      end
      begin
        int   n;
        bit   got;
        exp_t e;
        n = 0;
        got = 0;
        while (n < BUDGET) begin
          @(negedge clk);
          n++;
          if (rvalid) begin got = 1; break; end
        end
        n_checks++;
        if (!got) begin
          n_fail++; $display("FAIL clean_timeout: got no rvalid expected one within %0d cycles", BUDGET);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL clean_data: got %h expected %h", rdata, e.data); end
          n_checks++; if (nerr !== e.nerr) begin n_fail++; $display("FAIL clean_nerr: got %b expected %b", nerr, e.nerr); end
          n_checks++; if (cyc - t0 != STOP_LAT) begin n_fail++; $display("FAIL clean_latency: got %0d expected %0d", cyc - t0, STOP_LAT); end
          @(negedge clk);
          n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL clean_pulse: got %b expected 0", rvalid); end
        end
      end
    join
    idle_bits(2);
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL clean_ferr: got %0d expected %0d", fe_cnt, fe0); end
  endtask

  task automatic test_glitch();
    int rv0, fe0;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    for (int c = 0; c < (3 * BITC) / 10; c++) begin
      @(negedge clk);
      rxs = 1'b0;
      if (c == DIV) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
      end
    end
    idle_bits(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b expected 0", busy); end
    idle_bits(10);
    n_checks++; if (rv_cnt != rv0) begin n_fail++; $display("FAIL glitch_rvalid: got %0d expected %0d", rv_cnt, rv0); end
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", fe_cnt, fe0); end
  endtask

  task automatic test_break();
    int rv0, fe0;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, BITC, -1, -1, 0);
    repeat (20 * BITC) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low_line: got %b expected 1", busy); end
    rxs = 1'b1;
    repeat (14 * DIV) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_early: got %b expected 1", busy); end
    repeat (2 * DIV + 5) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_idle: got %b expected 0", busy); end
    idle_bits(2);
    n_checks++; if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL break_ferr_count: got %0d expected %0d", fe_cnt - fe0, 1); end
    n_checks++; if (rv_cnt != rv0) begin n_fail++; $display("FAIL break_rvalid: got %0d expected %0d", rv_cnt - rv0, 0); end
    n_checks++; if (fe_nerr !== 1'b0) begin n_fail++; $display("FAIL break_nerr: got %b expected 0", fe_nerr); end
  endtask

  task automatic test_noise();
    int spike;
    spike = (3 * OS + OS / 2 + 1) * DIV;
    exp_q.push_back('{data: 8'h55, nerr: 1'b1});
    fork
      send_frame(8'h55, 1'b1, BITC, spike - DIV / 2, spike - DIV / 2 + DIV, 0);
      begin
        int   n;
        bit   got;
        exp_t e;
        n = 0;
        got = 0;
        while (n < BUDGET) begin
          @(negedge clk);
          n++;
          if (rvalid) begin got = 1; break; end
        end
        n_checks++;
        if (!got) begin
          n_fail++; $display("FAIL noise_timeout: got no rvalid expected one within %0d cycles", BUDGET);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL noise_data: got %h expected %h", rdata, e.data); end
          n_checks++; if (nerr !== e.nerr) begin n_fail++; $display("FAIL noise_nerr: got %b expected %b", nerr, e.nerr); end
        end
      end
    join
    idle_bits(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[6];
    int         bitcs[6];
    bytes = '{8'h00, 8'hFF, 8'h81, 8'h00, 8'hFF, 8'h81};
    bitcs = '{82, 82, 82, 78, 78, 78};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          exp_q.push_back('{data: bytes[i], nerr: 1'b0});
          send_frame(bytes[i], 1'b1, bitcs[i], -1, -1, 0);
        end
        rxs = 1'b1;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          int   n;
          bit   got;
          exp_t e;
          n = 0;
          got = 0;
          while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (rvalid) begin got = 1; break; end
          end
          n_checks++;
          if (!got) begin
            n_fail++; $display("FAIL b2b_timeout: frame %0d got no rvalid expected one", k);
            break;
          end
          e = exp_q.pop_front();
          n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL b2b_data: frame %0d got %h expected %h", k, rdata, e.data); end
          n_checks++; if (nerr !== e.nerr) begin n_fail++; $display("FAIL b2b_nerr: frame %0d got %b expected %b", k, nerr, e.nerr); end
        end
      end
    join
    idle_bits(2);
  endtask

  task automatic test_reset_mid();
    int rv0, fe0;
    send_frame(8'hF0, 1'b1, BITC, -1, -1, 5 * BITC + BITC / 2);
    rxs = 1'b1;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    idle_bits(12);
    n_checks++; if (rv_cnt != rv0 || fe_cnt != fe0) begin
      n_fail++; $display("FAIL midrst_pulse: got rvalid=%0d ferr=%0d expected 0 0", rv_cnt - rv0, fe_cnt - fe0);
    end
    exp_q.push_back('{data: 8'h12, nerr: 1'b0});
    fork
      send_frame(8'h12, 1'b1, BITC, -1, -1, 0);
      begin
        int   n;
        bit   got;
        exp_t e;
        n = 0;
        got = 0;
        while (n < BUDGET) begin
          @(negedge clk);
          n++;
          if (rvalid) begin got = 1; break; end
        end
        n_checks++;
        if (!got) begin
          n_fail++; $display("FAIL midrst_timeout: got no rvalid expected one within %0d cycles", BUDGET);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (rdata !== e.data) begin n_fail++; $display("FAIL midrst_data: got %h expected %h", rdata, e.data); end
          n_checks++; if (nerr !== e.nerr) begin n_fail++; $display("FAIL midrst_nerr: got %b expected %b", nerr, e.nerr); end
        end
      end
    join
    idle_bits(2);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_break();
    test_noise();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
